// File: rtl/counterup16_1clk_posedge_async_reset.sv
// Purpose: WIDTH-bit up counter with enable, parallel load, free-run/one-shot mode and terminal-count pulse.
// Latency: every output is registered, one clock0 edge from input to output.
// Backpressure: none; inputs are sampled on every rising edge of clock0.
// Optional feature: define COUNTERUP16_WRAP_COUNT_EN to add the saturating 8-bit wrap_count output.
module counterup16_1clk_posedge_async_reset #(
   parameter int              WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             halted
`ifdef COUNTERUP16_WRAP_COUNT_EN
   ,
   output logic [7:0]       wrap_count
`endif
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALMOST   = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             wrap_evt;

   // State, count and terminal-count registers; reset clears them immediately.
   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         state <= RUN;
         count <= RESET_VALUE;
         tc    <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end

   // Next-state decode: load beats increment beats hold; one-shot stops at all-ones.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      tc_nxt    = 1'b0;
      wrap_evt  = 1'b0;
      if (load) begin
         state_nxt = RUN;
         count_nxt = load_value;
      end else begin
         case (state)
            RUN: begin
               if (enable) begin
                  if (count == ALL_ONES) begin
                     if (mode) begin
                        state_nxt = HALT;
                     end else begin
                        count_nxt = '0;
                        wrap_evt  = 1'b1;
                     end
                  end else begin
                     count_nxt = count + ONE;
                     tc_nxt    = (count == ALMOST);
                  end
               end
            end
            HALT: begin
               count_nxt = ALL_ONES;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // halted is the state register itself, so it is registered by construction.
   assign halted = (state == HALT);

`ifdef COUNTERUP16_WRAP_COUNT_EN
   // Saturating count of free-run wraps; a load restarts the tally.
   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         wrap_count <= 8'h00;
      end else if (load) begin
         wrap_count <= 8'h00;
      end else if (wrap_evt && (wrap_count != 8'hff)) begin
         wrap_count <= wrap_count + 8'h01;
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap_evt;
`endif

endmodule

// File: tb/tb_counterup16_1clk_posedge_async_reset.sv
// Purpose: scoreboard bench for the 16-bit up counter, directed scenarios plus random traffic.
// Latency: expected values are queued when inputs are driven and compared 1 time unit after the edge.
// Backpressure: not applicable; the counter accepts an input vector every cycle.
module tb_counterup16_1clk_posedge_async_reset;

   logic        clock0;
   logic        reset;
   logic        enable;
   logic        load;
   logic [15:0] load_value;
   logic        mode;
   logic [15:0] count;
   logic        tc;
   logic        halted;
`ifdef COUNTERUP16_WRAP_COUNT_EN
   logic [7:0]  wrap_count;
`endif

   typedef struct packed {
      logic [15:0] cnt;
      logic        tc;
      logic        halted;
      logic [7:0]  wraps;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] m_cnt;
   logic        m_halt;
   logic [7:0]  m_wraps;

   counterup16_1clk_posedge_async_reset #(
      .WIDTH(16),
      .RESET_VALUE(16'h0000)
   ) dut (
      .clock0(clock0),
      .reset(reset),
      .enable(enable),
      .load(load),
      .load_value(load_value),
      .mode(mode),
      .count(count),
      .tc(tc),
      .halted(halted)
`ifdef COUNTERUP16_WRAP_COUNT_EN
      ,
      .wrap_count(wrap_count)
`endif
   );

   initial clock0 = 1'b0;
   always #5 clock0 = ~clock0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 16'h0000;
      m_halt  = 1'b0;
      m_wraps = 8'h00;
   endtask

   // Drive one cycle of inputs, predict the outcome, then compare after the edge.
   task automatic step(input logic ld, input logic [15:0] lv, input logic en, input logic md);
      exp_t e;
      exp_t got;
      load       = ld;
      load_value = lv;
      enable     = en;
      mode       = md;
      e.tc = 1'b0;
      if (ld) begin
         m_cnt   = lv;
         m_halt  = 1'b0;
         m_wraps = 8'h00;
      end else if (!m_halt && en) begin
         if (m_cnt == 16'hffff) begin
            if (md) begin
               m_halt = 1'b1;
            end else begin
               m_cnt = 16'h0000;
               if (m_wraps != 8'hff) m_wraps = m_wraps + 8'h01;
            end
         end else begin
            e.tc  = (m_cnt == 16'hfffe);
            m_cnt = m_cnt + 16'h0001;
         end
      end
      e.cnt    = m_cnt;
      e.halted = m_halt;
      e.wraps  = m_wraps;
      exp_q.push_back(e);
      @(posedge clock0);
      #1;
      got = exp_q.pop_front();
      check("count", {16'h0, count}, {16'h0, got.cnt});
      check("tc", {31'h0, tc}, {31'h0, got.tc});
      check("halted", {31'h0, halted}, {31'h0, got.halted});
`ifdef COUNTERUP16_WRAP_COUNT_EN
      check("wrap_count", {24'h0, wrap_count}, {24'h0, got.wraps});
`endif
   endtask

   // Assert reset between edges and verify outputs clear without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      check({tag, "_count"}, {16'h0, count}, 32'h0);
      check({tag, "_tc"}, {31'h0, tc}, 32'h0);
      check({tag, "_halted"}, {31'h0, halted}, 32'h0);
`ifdef COUNTERUP16_WRAP_COUNT_EN
      check({tag, "_wrap"}, {24'h0, wrap_count}, 32'h0);
`endif
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      load       = 1'b0;
      load_value = 16'h0000;
      mode       = 1'b0;
      model_reset();
      #1;
      check("por_count", {16'h0, count}, 32'h0);
      check("por_tc", {31'h0, tc}, 32'h0);
      check("por_halted", {31'h0, halted}, 32'h0);
      #2;
      reset = 1'b0;

      // reset mid-count at 0x1234
      step(1'b1, 16'h1230, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("pre_rst_count", {16'h0, count}, 32'h1234);
      async_reset("rst_mid");

      // free-run wrap
      step(1'b1, 16'hfffd, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("fr_fffe", {15'h0, tc, count}, 32'h0_fffe);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("fr_ffff_tc", {15'h0, tc, count}, 32'h1_ffff);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("fr_0000", {15'h0, tc, count}, 32'h0_0000);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("fr_0001", {14'h0, halted, tc, count}, 32'h0_0001);
`ifdef COUNTERUP16_WRAP_COUNT_EN
      check("fr_wraps", {24'h0, wrap_count}, 32'h1);
`endif

      // reset while tc is high
      step(1'b1, 16'hfffe, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("pre_rst_tc", {31'h0, tc}, 32'h1);
      async_reset("rst_tc");

      // one-shot halt, held for 10 cycles whatever enable and mode do
      step(1'b1, 16'hfffe, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("os_ffff_tc", {15'h0, tc, count}, 32'h1_ffff);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("os_halt", {14'h0, halted, tc, count}, 32'h2_ffff);
      for (int i = 0; i < 10; i++)
         step(1'b0, 16'h0000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("os_held", {14'h0, halted, tc, count}, 32'h2_ffff);

      // load beats enable while halted
      step(1'b1, 16'h00a0, 1'b1, 1'b1);
      check("ld_halt", {14'h0, halted, tc, count}, 32'h0_00a0);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("ld_next", {16'h0, count}, 32'h00a1);

      // enable gating
      step(1'b1, 16'h0005, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("en_hold", {16'h0, count}, 32'h0006);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("en_resume", {16'h0, count}, 32'h0007);

      // loading all-ones: no tc; free-run wraps, one-shot halts
      step(1'b1, 16'hffff, 1'b1, 1'b0);
      check("ld_ones_tc", {15'h0, tc, count}, 32'h0_ffff);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("ld_ones_wrap", {16'h0, count}, 32'h0000);
      step(1'b1, 16'hffff, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("ld_ones_halt", {14'h0, halted, tc, count}, 32'h2_ffff);

      // mode switched to one-shot on the all-ones edge
      step(1'b1, 16'hfffe, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      check("mode_switch", {14'h0, halted, tc, count}, 32'h2_ffff);

      // random traffic biased toward the top of the range
      for (int i = 0; i < 400; i++) begin
         logic [15:0] lv;
         lv = ($urandom_range(0, 1) == 1) ? (16'hfff0 | 16'($urandom_range(0, 15)))
                                          : 16'($urandom_range(0, 65535));
         step(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
